// File: rtl/comparator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : comparator_pkg
//  Purpose  : Shared definitions for the comparator serializer front end:
//             sequencer state encoding and the comparator verdict codes.
//  Contents : IDLE..DONE 3-bit encodings, state_t enum, RES_* verdicts,
//             verdict_is_onehot() helper.
//  Revision : 1.0 - initial release
// ============================================================================
package comparator_pkg;

    localparam logic [2:0] IDLE_ENC  = 3'd0;
    localparam logic [2:0] CLR_ENC   = 3'd1;
    localparam logic [2:0] SHIFT_ENC = 3'd2;
    localparam logic [2:0] EVAL1_ENC = 3'd3;
    localparam logic [2:0] EVAL2_ENC = 3'd4;
    localparam logic [2:0] DONE_ENC  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = IDLE_ENC,
        ST_CLR   = CLR_ENC,
        ST_SHIFT = SHIFT_ENC,
        ST_EVAL1 = EVAL1_ENC,
        ST_EVAL2 = EVAL2_ENC,
        ST_DONE  = DONE_ENC
    } state_t;

    // Verdict codes as {L,E,G}
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    function automatic logic verdict_is_onehot(input logic [2:0] v);
        return (v == RES_LT) || (v == RES_EQ) || (v == RES_GT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_shift_reg
//  Purpose  : WIDTH-bit parallel-load shift register with a head-bit output.
//             Default build shifts MSB-first; defining
//             COMPARATOR_SERIALIZER_LSB_FIRST_EN makes it LSB-first.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             load_i        - load data_i (has priority over shift)
//             shift_i       - advance by one bit
//             data_i[W-1:0] - parallel load value
//             head_o        - bit that goes out this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             head_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
`ifdef COMPARATOR_SERIALIZER_LSB_FIRST_EN
            data_d = {1'b0, data_q[WIDTH-1:1]};
`else
            data_d = {data_q[WIDTH-2:0], 1'b0};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef COMPARATOR_SERIALIZER_LSB_FIRST_EN
    assign head_o = data_q[0];
`else
    assign head_o = data_q[WIDTH-1];
`endif

endmodule
`default_nettype wire

// File: rtl/comparator_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : comparator_serializer
//  Purpose  : Parallel-to-serial front end for a bit-serial magnitude
//             comparator. Accepts two WIDTH-bit operands, holds the
//             comparator in reset, streams one bit pair per cycle, requests
//             the verdict for two cycles and latches {L,E,G} with a done
//             pulse. Sequence: IDLE -> CLR -> SHIFT(xWIDTH) -> EVAL1 ->
//             EVAL2 -> DONE -> IDLE.
//  Option   : COMPARATOR_SERIALIZER_LSB_FIRST_EN - stream LSB first
//             (default MSB first).
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             load_valid/load_ready    - operand handshake
//             a_in, b_in [WIDTH-1:0]   - operands, sampled on accept
//             cmp_rst, a, b, op        - serial interface to comparator
//             L_in, E_in, G_in         - comparator verdict
//             busy, done, result[2:0], err - status / latched result
//  Revision : 1.0 - initial release
// ============================================================================
module comparator_serializer
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             cmp_rst,
    output logic             a,
    output logic             b,
    output logic             op,
    input  logic             L_in,
    input  logic             E_in,
    input  logic             G_in,
    output logic             busy,
    output logic             done,
    output logic [2:0]       result,
    output logic             err
);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      result_q, result_d;
    logic            err_q, err_d;
    logic            accept;
    logic            shift_en;
    logic            head_a, head_b;
    logic [2:0]      verdict;

    // rst is folded in so no operand is accepted on a reset edge and the
    // requester sees not-ready for the whole reset cycle.
    assign load_ready = (state_q == ST_IDLE) && !rst;
    assign accept     = load_ready && load_valid;
    assign shift_en   = (state_q == ST_SHIFT);
    assign verdict    = {L_in, E_in, G_in};

    serial_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (shift_en),
        .data_i  (a_in),
        .head_o  (head_a)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (shift_en),
        .data_i  (b_in),
        .head_o  (head_b)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    result_d = RES_NONE;
                    err_d    = 1'b0;
                    state_d  = ST_CLR;
                end
            end
            ST_CLR: begin
                cnt_d   = CW'(WIDTH - 1);
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_EVAL1;
                end
            end
            ST_EVAL1: begin
                state_d = ST_EVAL2;
            end
            ST_EVAL2: begin
                // Verdict sampled after two op cycles so the comparator has
                // a full cycle to present it.
                result_d = verdict;
                err_d    = !verdict_is_onehot(verdict);
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= RES_NONE;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // All outputs below decode flops only; nothing passes from an input.
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign op      = (state_q == ST_EVAL1) || (state_q == ST_EVAL2);
    assign cmp_rst = (state_q == ST_IDLE) || (state_q == ST_CLR) ||
                     (state_q == ST_DONE);
    assign a       = shift_en && head_a;
    assign b       = shift_en && head_b;
    assign result  = result_q;
    assign err     = err_q;

endmodule
`default_nettype wire
